seg7_scan_driver: RTL

- Parametrised, time-multiplexed driver for a common-segment, multi-digit 7-segment display.
- Successor to the single-digit hex-to-segment decoder.
- Latches a packed vector of 4-bit digit codes and scans the digits one at a time, with a ghost-blanking interval between digits.
- Adds per-digit enable, decimal points, BCD/hex mode, leading-zero suppression and tear-free frame-synchronous updates.
- Sits between the counter/datapath logic and the board display pins.

---
 rtl/seg7_scan_if.sv | 26 ++
 rtl/seg7_scan_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// Bundles the display driver's data inputs and display pin outputs.
// Signal prefixes are from the driver's (slave) side.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 4
) ();
  logic [4*DIGITS-1:0] i_din;
  logic [DIGITS-1:0]   i_dp_in;
  logic [DIGITS-1:0]   i_digit_en;
  logic                i_load;
  logic                i_hex_mode;
  logic                i_lzs;
  logic [6:0]          o_seg;
  logic                o_dp;
  logic [DIGITS-1:0]   o_an;
  logic                o_frame_done;

  modport master (
    output i_din, i_dp_in, i_digit_en, i_load, i_hex_mode, i_lzs,
    input  o_seg, o_dp, o_an, o_frame_done
  );

  modport slave (
    input  i_din, i_dp_in, i_digit_en, i_load, i_hex_mode, i_lzs,
    output o_seg, o_dp, o_an, o_frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver: blanked digit slots, BCD/hex decode,
// leading-zero suppression and frame-synchronous (tear-free) display updates.
module seg7_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  seg7_scan_if.slave  io_bus
);

  localparam int unsigned      CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned      IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax = IdxW'(DIGITS - 1);
  localparam logic [6:0]       SegInv = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic             DpInv  = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AnInv = (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  typedef enum logic [0:0] {StBlank, StOn} state_e;
  localparam state_e StFirst = (BLANK_CYCLES != 0) ? StBlank : StOn;

  logic [CntW-1:0]         r_cnt, w_cnt_d;
  logic [IdxW-1:0]         r_idx, w_idx_d;
  state_e                  r_state, w_state_d;
  logic                    w_wrap, w_blank_next, w_frame_start;

  logic [DIGITS-1:0][3:0]  r_shadow, r_disp;
  logic [DIGITS-1:0]       r_shadow_dp, r_disp_dp;
  logic                    r_pending;

  logic [3:0]              w_code;
  logic [6:0]              w_seg_act;
  logic [DIGITS-1:0]       w_supp;
  logic                    w_lz_acc, w_dark;
  logic [6:0]              w_seg_d, r_seg;
  logic                    w_dp_d, r_dp;
  logic [DIGITS-1:0]       w_an_d, r_an;
  logic                    w_fd_d, r_frame_done;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
    endcase
    return s;
  endfunction

  assign w_wrap        = (r_cnt == CntMax);
  assign w_frame_start = (r_cnt == '0) && (r_idx == '0);

  // Blank phase membership is decided from the count the slot is about to hold.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign w_blank_next = 1'b0;
  end else begin : g_blank
    localparam logic [CntW-1:0] BlankLim = CntW'(BLANK_CYCLES);
    assign w_blank_next = (w_cnt_d < BlankLim);
  end

  always_comb begin
    w_cnt_d   = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_d   = r_idx;
    if (w_wrap) begin
      w_idx_d = (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
    end
    w_state_d = w_blank_next ? StBlank : StOn;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= StFirst;
    end else begin
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_state <= w_state_d;
    end
  end

  // A load coinciding with the frame start bypasses the shadow and leaves nothing pending.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_disp      <= '0;
      r_disp_dp   <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (io_bus.i_load) begin
        r_shadow    <= io_bus.i_din;
        r_shadow_dp <= io_bus.i_dp_in;
      end
      if (w_frame_start && io_bus.i_load) begin
        r_disp    <= io_bus.i_din;
        r_disp_dp <= io_bus.i_dp_in;
        r_pending <= 1'b0;
      end else if (w_frame_start && r_pending) begin
        r_disp    <= r_shadow;
        r_disp_dp <= r_shadow_dp;
        r_pending <= 1'b0;
      end else if (io_bus.i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_code    = r_disp[r_idx];
    w_seg_act = f_decode(w_code);
    w_lz_acc  = 1'b1;
    w_supp    = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      w_lz_acc  = w_lz_acc & (r_disp[i] == 4'h0);
      w_supp[i] = w_lz_acc & io_bus.i_lzs & (i != 0);
    end
    w_dark = !io_bus.i_digit_en[r_idx] || (!io_bus.i_hex_mode && (w_code > 4'd9)) ||
             w_supp[r_idx];

    w_seg_d = SegInv;
    w_dp_d  = DpInv;
    w_an_d  = AnInv;
    if (r_state == StOn) begin
      w_an_d = AnInv ^ (DIGITS'(1) << r_idx);
      if (!w_dark) begin
        w_seg_d = w_seg_act ^ SegInv;
        w_dp_d  = r_disp_dp[r_idx] ^ DpInv;
      end
    end
    w_fd_d = w_wrap && (r_idx == IdxMax);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_seg        <= SegInv;
      r_dp         <= DpInv;
      r_an         <= AnInv;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_d;
      r_dp         <= w_dp_d;
      r_an         <= w_an_d;
      r_frame_done <= w_fd_d;
    end
  end

  assign io_bus.o_seg        = r_seg;
  assign io_bus.o_dp         = r_dp;
  assign io_bus.o_an         = r_an;
  assign io_bus.o_frame_done = r_frame_done;

endmodule
